// File: rtl/dual_issue_queue_pkg.sv
// Shared definitions for the dual-issue instruction queue.
package dual_issue_queue_pkg;

  localparam int unsigned IQ_LANES = 2;

  typedef logic [1:0] lane_n_t;

  // Lane-count encoding shared by enqueue and dequeue: lane1 only counts behind lane0.
  function automatic lane_n_t lane_cnt(input logic v0, input logic v1);
    return v0 ? (v1 ? 2'd2 : 2'd1) : 2'd0;
  endfunction

endpackage

// File: rtl/dual_issue_queue_ptr.sv
// Pointer/count bookkeeping for dual_issue_queue: enq/deq lane counts, flush and reset.
module dual_issue_queue_ptr
  import dual_issue_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid0,
  input  logic          in_valid1,
  input  logic          issue0,
  input  logic          issue1,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count,
  output logic          enq_ready,
  output logic          out_valid0,
  output logic          out_valid1,
  output logic          wr_en0,
  output logic          wr_en1
);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  lane_n_t       w_enq_n;
  lane_n_t       w_deq_n;

  // Credit comes from the registered count only; a same-cycle dequeue frees nothing.
  assign enq_ready  = (CW'(DEPTH) - r_count) >= CW'(IQ_LANES);
  assign out_valid0 = (r_count != '0);
  assign out_valid1 = (r_count >= CW'(2));

  assign w_enq_n = lane_cnt(enq_ready & in_valid0, in_valid1);
  assign w_deq_n = lane_cnt(issue0 & out_valid0, issue1 & out_valid1);

  assign wr_en0 = (w_enq_n != 2'd0) & ~flush;
  assign wr_en1 = (w_enq_n == 2'd2) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_deq_n);
      r_wr_ptr <= r_wr_ptr + PW'(w_enq_n);
      r_count  <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
    end
  end

  assign rd_ptr = r_rd_ptr;
  assign wr_ptr = r_wr_ptr;
  assign count  = r_count;

endmodule

// File: rtl/dual_issue_queue.sv
// In-order 2-wide issue queue: entry storage and slot read muxes.
// Optional perf counters enabled by defining YSYX22040228_IQ_PERF_EN.
module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter  int unsigned DEPTH     = 8,
  parameter  int unsigned PAYLOAD_W = 64,
  parameter  int unsigned PC_W      = 64,
  localparam int unsigned PW        = $clog2(DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid0,
  input  logic [PC_W-1:0]      in_pc0,
  input  logic [PAYLOAD_W-1:0] in_pay0,
  input  logic                 in_valid1,
  input  logic [PC_W-1:0]      in_pc1,
  input  logic [PAYLOAD_W-1:0] in_pay1,
  output logic                 enq_ready,
  output logic                 out_valid0,
  output logic [PC_W-1:0]      out_pc0,
  output logic [PAYLOAD_W-1:0] out_pay0,
  output logic                 out_valid1,
  output logic [PC_W-1:0]      out_pc1,
  output logic [PAYLOAD_W-1:0] out_pay1,
  input  logic                 issue0,
  input  logic                 issue1,
  output logic [CW-1:0]        occupancy
`ifdef YSYX22040228_IQ_PERF_EN
  ,
  output logic [31:0]          perf_full_cyc,
  output logic [31:0]          perf_stall_cyc
`endif
);

  logic [PC_W-1:0]      r_pc  [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay [DEPTH];

  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr1;
  logic [PW-1:0] w_wr_ptr1;
  logic          w_wr_en0;
  logic          w_wr_en1;

  dual_issue_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid0  (in_valid0),
    .in_valid1  (in_valid1),
    .issue0     (issue0),
    .issue1     (issue1),
    .rd_ptr     (w_rd_ptr),
    .wr_ptr     (w_wr_ptr),
    .count      (occupancy),
    .enq_ready  (enq_ready),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .wr_en0     (w_wr_en0),
    .wr_en1     (w_wr_en1)
  );

  assign w_rd_ptr1 = w_rd_ptr + PW'(1);
  assign w_wr_ptr1 = w_wr_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (w_wr_en0) begin
      r_pc[w_wr_ptr]  <= in_pc0;
      r_pay[w_wr_ptr] <= in_pay0;
    end
    if (w_wr_en1) begin
      r_pc[w_wr_ptr1]  <= in_pc1;
      r_pay[w_wr_ptr1] <= in_pay1;
    end
  end

  // Invalid slots read as zero so stale array contents never leak downstream.
  assign out_pc0  = out_valid0 ? r_pc[w_rd_ptr]   : '0;
  assign out_pay0 = out_valid0 ? r_pay[w_rd_ptr]  : '0;
  assign out_pc1  = out_valid1 ? r_pc[w_rd_ptr1]  : '0;
  assign out_pay1 = out_valid1 ? r_pay[w_rd_ptr1] : '0;

`ifdef YSYX22040228_IQ_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_stall;

  // Saturating; flush deliberately leaves these alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_full  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (!enq_ready && in_valid0 && (r_perf_full != '1))
        r_perf_full <= r_perf_full + 32'd1;
      if (out_valid0 && !issue0 && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_full_cyc  = r_perf_full;
  assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed, table-driven bench for dual_issue_queue (DEPTH=8, 64-bit PC/payload).
module tb_dual_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid0, in_valid1;
  logic [63:0] in_pc0, in_pc1, in_pay0, in_pay1;
  logic        enq_ready;
  logic        out_valid0, out_valid1;
  logic [63:0] out_pc0, out_pc1, out_pay0, out_pay1;
  logic        issue0, issue1;
  logic [3:0]  occupancy;
`ifdef YSYX22040228_IQ_PERF_EN
  logic [31:0] perf_full_cyc, perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  dual_issue_queue #(.DEPTH(8), .PAYLOAD_W(64), .PC_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid0  (in_valid0),
    .in_pc0     (in_pc0),
    .in_pay0    (in_pay0),
    .in_valid1  (in_valid1),
    .in_pc1     (in_pc1),
    .in_pay1    (in_pay1),
    .enq_ready  (enq_ready),
    .out_valid0 (out_valid0),
    .out_pc0    (out_pc0),
    .out_pay0   (out_pay0),
    .out_valid1 (out_valid1),
    .out_pc1    (out_pc1),
    .out_pay1   (out_pay1),
    .issue0     (issue0),
    .issue1     (issue1),
    .occupancy  (occupancy)
`ifdef YSYX22040228_IQ_PERF_EN
    ,
    .perf_full_cyc  (perf_full_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic fl, v0, v1;
    int   k0, k1;
    logic i0, i1;
    int   eocc;
    logic erdy;
    int   ek0, ek1;
  } vec_t;

  vec_t vt[17];

  function automatic logic [63:0] pcv(input int k);
    return 64'h8000_0000 + 64'(4 * k);
  endfunction

  function automatic logic [63:0] payv(input logic [63:0] pc);
    return {pc[31:0], ~pc[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ek < 0 means the slot is expected empty (valid 0, PC/payload 0).
  task automatic chk_state(input string tag, input int eocc, input logic erdy,
                           input int ek0, input int ek1);
    logic [63:0] epc0, epc1;
    epc0 = (ek0 >= 0) ? pcv(ek0) : 64'd0;
    epc1 = (ek1 >= 0) ? pcv(ek1) : 64'd0;
    chk({tag, ".occ"},  64'(occupancy),  64'(eocc));
    chk({tag, ".rdy"},  64'(enq_ready),  64'(erdy));
    chk({tag, ".ov0"},  64'(out_valid0), 64'(ek0 >= 0));
    chk({tag, ".ov1"},  64'(out_valid1), 64'(ek1 >= 0));
    chk({tag, ".pc0"},  out_pc0,  epc0);
    chk({tag, ".pc1"},  out_pc1,  epc1);
    chk({tag, ".pay0"}, out_pay0, (ek0 >= 0) ? payv(epc0) : 64'd0);
    chk({tag, ".pay1"}, out_pay1, (ek1 >= 0) ? payv(epc1) : 64'd0);
  endtask

  task automatic step(input logic fl, input logic v0, input logic v1, input int k0,
                      input int k1, input logic i0, input logic i1);
    @(negedge clk);
    flush     = fl;
    in_valid0 = v0;
    in_valid1 = v1;
    in_pc0    = pcv(k0);
    in_pc1    = pcv(k1);
    in_pay0   = payv(pcv(k0));
    in_pay1   = payv(pcv(k1));
    issue0    = i0;
    issue1    = i1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          fl  v0  v1  k0  k1  i0  i1  occ rdy ek0 ek1
    vt[0]  = '{1'b0,1'b1,1'b1, 0, 1,1'b0,1'b0, 2,1'b1, 0, 1};
    vt[1]  = '{1'b0,1'b1,1'b1, 2, 3,1'b0,1'b0, 4,1'b1, 0, 1};
    vt[2]  = '{1'b0,1'b1,1'b1, 4, 5,1'b0,1'b0, 6,1'b1, 0, 1};
    vt[3]  = '{1'b0,1'b1,1'b1, 6, 7,1'b0,1'b0, 8,1'b0, 0, 1};
    vt[4]  = '{1'b0,1'b1,1'b1, 8, 9,1'b0,1'b0, 8,1'b0, 0, 1};
    vt[5]  = '{1'b0,1'b0,1'b0, 0, 0,1'b1,1'b0, 7,1'b0, 1, 2};
    vt[6]  = '{1'b0,1'b0,1'b0, 0, 0,1'b0,1'b1, 7,1'b0, 1, 2};
    vt[7]  = '{1'b0,1'b0,1'b0, 0, 0,1'b1,1'b1, 5,1'b1, 3, 4};
    vt[8]  = '{1'b0,1'b1,1'b0, 8, 0,1'b1,1'b1, 4,1'b1, 5, 6};
    vt[9]  = '{1'b0,1'b0,1'b1, 0, 9,1'b0,1'b0, 4,1'b1, 5, 6};
    vt[10] = '{1'b0,1'b0,1'b0, 0, 0,1'b1,1'b1, 2,1'b1, 7, 8};
    vt[11] = '{1'b0,1'b0,1'b0, 0, 0,1'b1,1'b0, 1,1'b1, 8,-1};
    vt[12] = '{1'b0,1'b0,1'b0, 0, 0,1'b1,1'b1, 0,1'b1,-1,-1};
    vt[13] = '{1'b0,1'b0,1'b0, 0, 0,1'b1,1'b1, 0,1'b1,-1,-1};
    vt[14] = '{1'b0,1'b1,1'b1, 9,10,1'b0,1'b0, 2,1'b1, 9,10};
    vt[15] = '{1'b1,1'b1,1'b1,11,12,1'b1,1'b1, 0,1'b1,-1,-1};
    vt[16] = '{1'b0,1'b1,1'b1,11,12,1'b0,1'b0, 2,1'b1,11,12};

    rst = 1'b1; flush = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_pc0 = '0; in_pc1 = '0; in_pay0 = '0; in_pay1 = '0;
    issue0 = 1'b0; issue1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state("reset", 0, 1'b1, -1, -1);

    for (int i = 0; i < 17; i++)
      begin
        step(vt[i].fl, vt[i].v0, vt[i].v1, vt[i].k0, vt[i].k1, vt[i].i0, vt[i].i1);
        chk_state($sformatf("vec%0d", i), vt[i].eocc, vt[i].erdy, vt[i].ek0, vt[i].ek1);
      end

    // Fill to 6, then steady 2-in/2-out across pointer wrap.
    step(1'b0, 1'b1, 1'b1, 13, 14, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 15, 16, 1'b0, 1'b0);
    chk_state("fill6", 6, 1'b1, 11, 12);
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b1, 1'b1, 15 + 2 * j, 16 + 2 * j, 1'b1, 1'b1);
      chk_state($sformatf("steady%0d", j), 6, 1'b1, 11 + 2 * j, 12 + 2 * j);
    end

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b1, -1, -1);
    @(negedge clk);
    rst = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; issue0 = 1'b0; issue1 = 1'b0;

`ifdef YSYX22040228_IQ_PERF_EN
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b1, 2 * j, 2 * j + 1, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b0, 40, 41, 1'b0, 1'b0);
    chk("perf_full", 64'(perf_full_cyc), 64'd5);
    chk("perf_stall", 64'(perf_stall_cyc), 64'd8);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk_state("perf_flush", 0, 1'b1, -1, -1);
    chk("perf_full_flush", 64'(perf_full_cyc), 64'd5);
    chk("perf_stall_flush", 64'(perf_stall_cyc), 64'd9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
